lru_age_tracker: RTL and testbench

Parametrised true-LRU replacement state for one cache level of the simulator. Holds an age counter per way for every set, applies touch, victim-query and invalidate operations through a valid/ready request port, and returns the victim way one cycle after a query. It replaces per-configuration hard-coded LRU updaters: one instance serves any power-of-two associativity and set count, initialises its own state after reset, and supports invalidation.

---
 rtl/lru_age_tracker.sv | 153 +++++++++++++++
 tb/tb_lru_age_tracker.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lru_age_tracker.sv
// lru_age_tracker
//
// True-LRU replacement state for one cache level. Each set holds one age per
// way: age 0 is the most recently used way and age WAYS-1 is the least
// recently used way. The ages in a set are always a permutation of
// 0..WAYS-1. After reset the block walks every set once and writes
// age[s][w] = w. It then accepts touch, victim-query and invalidate requests,
// one per cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  block accepts a request this cycle (high once initialised)
//   req_op     00 touch, 01 victim query, 10 invalidate, 11 reserved (no-op)
//   req_index  target set
//   req_way    target way for touch/invalidate
//   rsp_valid  one-cycle pulse carrying the victim of an accepted query
//   rsp_way    victim way (the way holding age WAYS-1)
//   rsp_index  set index echoed from the query
//   init_done  state array has been initialised
module lru_age_tracker #(
    parameter int WAYS = 8,
    parameter int SETS = 16384,
    localparam int WAY_W = $clog2(WAYS),
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [IDX_W-1:0] req_index,
    input  logic [WAY_W-1:0] req_way,
    output logic             rsp_valid,
    output logic [WAY_W-1:0] rsp_way,
    output logic [IDX_W-1:0] rsp_index,
    output logic             init_done
);

    localparam int SET_W = WAYS * WAY_W;
    localparam logic [1:0] OP_TOUCH = 2'b00;
    localparam logic [1:0] OP_QUERY = 2'b01;
    localparam logic [1:0] OP_INVAL = 2'b10;
    localparam logic [WAY_W-1:0] AGE_LRU = WAY_W'(WAYS - 1);
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_initCnt;
    logic [SET_W-1:0] r_age [SETS];
    logic             r_ready;
    logic             r_initDone;
    logic             r_rspValid;
    logic [WAY_W-1:0] r_rspWay;
    logic [IDX_W-1:0] r_rspIndex;

    logic             w_accept;
    logic             w_doWrite;
    logic [SET_W-1:0] w_curSet;
    logic [SET_W-1:0] w_newSet;
    logic [SET_W-1:0] w_initSet;
    logic [WAY_W-1:0] w_targetAge;
    logic [WAY_W-1:0] w_victim;

    assign w_accept  = req_valid && r_ready;
    assign w_doWrite = w_accept && ((req_op == OP_TOUCH) || (req_op == OP_INVAL));

    // The addressed set is read combinationally and its updated value is
    // written back at the accepting edge. A request to the same set in the
    // next cycle therefore reads the new ages directly, so no bypass is needed.
    // Touch promotes the way to age 0 and ages every younger way by one.
    // Invalidate demotes the way to age WAYS-1 and rejuvenates every older way
    // by one. Both updates keep the set a permutation.
    always_comb begin
        w_curSet    = r_age[req_index];
        w_targetAge = w_curSet[req_way*WAY_W +: WAY_W];
        w_newSet    = w_curSet;
        w_initSet   = '0;
        w_victim    = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_initSet[w*WAY_W +: WAY_W] = WAY_W'(w);
            if (w_curSet[w*WAY_W +: WAY_W] == AGE_LRU) begin
                w_victim = WAY_W'(w);
            end
            if (req_op == OP_TOUCH) begin
                if (WAY_W'(w) == req_way) begin
                    w_newSet[w*WAY_W +: WAY_W] = '0;
                end else if (w_curSet[w*WAY_W +: WAY_W] < w_targetAge) begin
                    w_newSet[w*WAY_W +: WAY_W] = w_curSet[w*WAY_W +: WAY_W] + WAY_W'(1);
                end
            end else if (req_op == OP_INVAL) begin
                if (WAY_W'(w) == req_way) begin
                    w_newSet[w*WAY_W +: WAY_W] = AGE_LRU;
                end else if (w_curSet[w*WAY_W +: WAY_W] > w_targetAge) begin
                    w_newSet[w*WAY_W +: WAY_W] = w_curSet[w*WAY_W +: WAY_W] - WAY_W'(1);
                end
            end
        end
    end

    // Control FSM. INIT writes one set per cycle. RUN serves requests.
    // A reset in any state discards a pending response and restarts the walk.
    // The age array is not reset because INIT rewrites every set anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_initCnt  <= '0;
            r_ready    <= 1'b0;
            r_initDone <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspWay   <= '0;
            r_rspIndex <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_age[r_initCnt] <= w_initSet;
                    r_initCnt        <= r_initCnt + IDX_W'(1);
                    r_rspValid       <= 1'b0;
                    if (r_initCnt == LAST_SET) begin
                        r_state    <= ST_RUN;
                        r_ready    <= 1'b1;
                        r_initDone <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_rspValid <= w_accept && (req_op == OP_QUERY);
                    if (w_accept && (req_op == OP_QUERY)) begin
                        r_rspWay   <= w_victim;
                        r_rspIndex <= req_index;
                    end
                    if (w_doWrite) begin
                        r_age[req_index] <= w_newSet;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign init_done = r_initDone;
    assign rsp_valid = r_rspValid;
    assign rsp_way   = r_rspWay;
    assign rsp_index = r_rspIndex;

endmodule

// File: tb/tb_lru_age_tracker.sv
// Testbench for lru_age_tracker. Three instances share one stimulus bus:
// 4-way (directed scenarios), 8-way and 2-way (random stress). Every
// instance has 16 sets. The reference model keeps each set as a recency list
// (MRU first), so the victim is simply the tail of that list.
module tb_lru_age_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] valid;
    logic [1:0] op;
    logic [3:0] idx;
    logic [2:0] way;

    logic [2:0] ready;
    logic [2:0] rspValid;
    logic [2:0] initDone;
    logic [3:0] rspIndex0, rspIndex1, rspIndex2;
    logic [1:0] rspWay0;
    logic [2:0] rspWay1;
    logic [0:0] rspWay2;

    int checks = 0;
    int errors = 0;
    int order [16][$];

    always #5 clk = ~clk;

    lru_age_tracker #(.WAYS(4), .SETS(16)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(valid[0]), .req_ready(ready[0]),
        .req_op(op), .req_index(idx), .req_way(way[1:0]),
        .rsp_valid(rspValid[0]), .rsp_way(rspWay0), .rsp_index(rspIndex0),
        .init_done(initDone[0])
    );

    lru_age_tracker #(.WAYS(8), .SETS(16)) u_dut8 (
        .clk(clk), .rst(rst), .req_valid(valid[1]), .req_ready(ready[1]),
        .req_op(op), .req_index(idx), .req_way(way),
        .rsp_valid(rspValid[1]), .rsp_way(rspWay1), .rsp_index(rspIndex1),
        .init_done(initDone[1])
    );

    lru_age_tracker #(.WAYS(2), .SETS(16)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(valid[2]), .req_ready(ready[2]),
        .req_op(op), .req_index(idx), .req_way(way[0:0]),
        .rsp_valid(rspValid[2]), .rsp_way(rspWay2), .rsp_index(rspIndex2),
        .init_done(initDone[2])
    );

    function automatic int rspWayOf(int sel);
        if (sel == 0) return int'(rspWay0);
        if (sel == 1) return int'(rspWay1);
        return int'(rspWay2);
    endfunction

    function automatic int rspIndexOf(int sel);
        if (sel == 0) return int'(rspIndex0);
        if (sel == 1) return int'(rspIndex1);
        return int'(rspIndex2);
    endfunction

    function automatic bit permOk(logic [23:0] vec, int ways, int ww);
        int seen = 0;
        for (int w = 0; w < ways; w++) begin
            int a = int'((vec >> (w * ww)) & 24'((1 << ww) - 1));
            seen = seen | (1 << a);
        end
        return seen == ((1 << ways) - 1);
    endfunction

    task automatic modelReset(input int ways);
        for (int s = 0; s < 16; s++) begin
            order[s].delete();
            for (int w = 0; w < ways; w++) order[s].push_back(w);
        end
    endtask

    task automatic modelApply(input int o, input int s, input int w);
        if (o == 0 || o == 2) begin
            for (int i = 0; i < order[s].size(); i++) begin
                if (order[s][i] == w) begin
                    order[s].delete(i);
                    break;
                end
            end
            if (o == 0) order[s].push_front(w);
            else order[s].push_back(w);
        end
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic waitInit(input int sel, output int cycles);
        cycles = 0;
        while (initDone[sel] !== 1'b1 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic doOp(input int sel, input logic [1:0] o, input int s, input int w);
        op = o;
        idx = s[3:0];
        way = w[2:0];
        valid = '0;
        valid[sel] = 1'b1;
        @(posedge clk); #1;
        valid = '0;
    endtask

    task automatic test_reset();
        int cycles;
        rst = 1'b1;
        valid = '0;
        op = 2'b00;
        idx = '0;
        way = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready[0]); end
        checks++;
        if (rspValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rspValid[0]); end
        checks++;
        if (rspWay0 !== 2'd0) begin errors++; $display("[TB] FAIL reset_rsp_way: got %0d expected 0", rspWay0); end
        checks++;
        if (rspIndex0 !== 4'd0) begin errors++; $display("[TB] FAIL reset_rsp_index: got %0d expected 0", rspIndex0); end
        checks++;
        if (initDone[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_done: got %b expected 0", initDone[0]); end
        rst = 1'b0;
        op = 2'b00;
        idx = 4'd5;
        way = 3'd3;
        valid[0] = 1'b1;
        waitInit(0, cycles);
        valid = '0;
        checks++;
        if (cycles != 16) begin errors++; $display("[TB] FAIL init_length: got %0d cycles expected 16", cycles); end
    endtask

    task automatic test_init();
        doOp(0, 2'b01, 5, 0);
        checks++;
        if (rspValid[0] !== 1'b1) begin errors++; $display("[TB] FAIL init_query_valid: got %b expected 1", rspValid[0]); end
        checks++;
        if (rspWay0 !== 2'd3) begin errors++; $display("[TB] FAIL init_query_way: got %0d expected 3", rspWay0); end
        checks++;
        if (rspIndex0 !== 4'd5) begin errors++; $display("[TB] FAIL init_query_index: got %0d expected 5", rspIndex0); end
        @(posedge clk); #1;
        checks++;
        if (rspValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL rsp_pulse_width: got %b expected 0", rspValid[0]); end
    endtask

    task automatic test_touch_order();
        int seq [4] = '{3, 2, 1, 0};
        foreach (seq[i]) begin
            doOp(0, 2'b00, 2, seq[i]);
            checks++;
            if (rspValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL touch_no_rsp: got %b expected 0", rspValid[0]); end
        end
        doOp(0, 2'b01, 2, 0);
        checks++;
        if (rspValid[0] !== 1'b1 || rspWay0 !== 2'd3) begin
            errors++; $display("[TB] FAIL touch_order_victim: got valid %b way %0d expected valid 1 way 3", rspValid[0], rspWay0);
        end
        doOp(0, 2'b00, 2, 3);
        doOp(0, 2'b01, 2, 0);
        checks++;
        if (rspValid[0] !== 1'b1 || rspWay0 !== 2'd2) begin
            errors++; $display("[TB] FAIL touch_retouch_victim: got valid %b way %0d expected valid 1 way 2", rspValid[0], rspWay0);
        end
        checks++;
        if (!permOk(24'(u_dut4.r_age[2]), 4, 2)) begin
            errors++; $display("[TB] FAIL touch_perm: got ages %h expected a permutation", u_dut4.r_age[2]);
        end
    endtask

    task automatic test_invalidate();
        for (int w = 0; w < 4; w++) doOp(0, 2'b00, 7, w);
        doOp(0, 2'b01, 7, 0);
        checks++;
        if (rspWay0 !== 2'd0) begin errors++; $display("[TB] FAIL inval_pre_victim: got %0d expected 0", rspWay0); end
        doOp(0, 2'b10, 7, 2);
        checks++;
        if (rspValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL inval_no_rsp: got %b expected 0", rspValid[0]); end
        doOp(0, 2'b01, 7, 0);
        checks++;
        if (rspValid[0] !== 1'b1 || rspWay0 !== 2'd2) begin
            errors++; $display("[TB] FAIL inval_victim: got valid %b way %0d expected valid 1 way 2", rspValid[0], rspWay0);
        end
        doOp(0, 2'b00, 7, 2);
        doOp(0, 2'b01, 7, 0);
        checks++;
        if (rspWay0 !== 2'd0) begin errors++; $display("[TB] FAIL inval_touch_victim: got %0d expected 0", rspWay0); end
    endtask

    task automatic test_back_to_back();
        doOp(0, 2'b00, 9, 3);
        doOp(0, 2'b01, 9, 0);
        checks++;
        if (rspValid[0] !== 1'b1 || rspWay0 !== 2'd2 || rspIndex0 !== 4'd9) begin
            errors++; $display("[TB] FAIL back_to_back: got valid %b way %0d index %0d expected valid 1 way 2 index 9", rspValid[0], rspWay0, rspIndex0);
        end
    endtask

    task automatic test_reset_mid();
        int cycles;
        pulseReset();
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (initDone[0] !== 1'b0) begin errors++; $display("[TB] FAIL mid_init_done: got %b expected 0", initDone[0]); end
        pulseReset();
        waitInit(0, cycles);
        checks++;
        if (cycles != 16) begin errors++; $display("[TB] FAIL mid_init_restart: got %0d cycles expected 16", cycles); end
        doOp(0, 2'b01, 2, 0);
        checks++;
        if (rspWay0 !== 2'd3) begin errors++; $display("[TB] FAIL mid_reinit_victim: got %0d expected 3", rspWay0); end
        doOp(0, 2'b01, 9, 0);
        rst = 1'b1;
        valid[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rspValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL rst_discards_rsp: got %b expected 0", rspValid[0]); end
        valid = '0;
        rst = 1'b0;
        waitInit(0, cycles);
        checks++;
        if (cycles != 16) begin errors++; $display("[TB] FAIL rst_rsp_init_length: got %0d cycles expected 16", cycles); end
        doOp(0, 2'b01, 9, 0);
        checks++;
        if (rspValid[0] !== 1'b1 || rspWay0 !== 2'd3) begin
            errors++; $display("[TB] FAIL post_reset_victim: got valid %b way %0d expected valid 1 way 3", rspValid[0], rspWay0);
        end
    endtask

    task automatic test_stress(input int sel, input int ways, input int ww);
        int cycles;
        pulseReset();
        waitInit(sel, cycles);
        checks++;
        if (cycles != 16) begin errors++; $display("[TB] FAIL stress_init_%0d: got %0d cycles expected 16", ways, cycles); end
        modelReset(ways);
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
                checks++;
                if (rspValid[sel] !== 1'b0) begin errors++; $display("[TB] FAIL stress_idle_%0d: got %b expected 0", ways, rspValid[sel]); end
            end else begin
                int o = int'($urandom_range(0, 3));
                int s = int'($urandom_range(0, 15));
                int w = int'($urandom_range(0, ways - 1));
                logic [23:0] vec;
                doOp(sel, 2'(o), s, w);
                modelApply(o, s, w);
                if (o == 1) begin
                    int exp = order[s][order[s].size() - 1];
                    checks++;
                    if (rspValid[sel] !== 1'b1 || rspWayOf(sel) != exp || rspIndexOf(sel) != s) begin
                        errors++;
                        $display("[TB] FAIL stress_query_%0d: got valid %b way %0d index %0d expected valid 1 way %0d index %0d",
                                 ways, rspValid[sel], rspWayOf(sel), rspIndexOf(sel), exp, s);
                    end
                end else begin
                    checks++;
                    if (rspValid[sel] !== 1'b0) begin errors++; $display("[TB] FAIL stress_no_rsp_%0d: op %0d got %b expected 0", ways, o, rspValid[sel]); end
                end
                if (sel == 1) vec = 24'(u_dut8.r_age[s]);
                else vec = 24'(u_dut2.r_age[s]);
                checks++;
                if (!permOk(vec, ways, ww)) begin
                    errors++; $display("[TB] FAIL stress_perm_%0d: set %0d ages %h expected a permutation", ways, s, vec);
                end
            end
        end
    endtask

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_init();
        test_touch_order();
        test_invalidate();
        test_back_to_back();
        test_reset_mid();
        test_stress(1, 8, 3);
        test_stress(2, 2, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
